// File: rtl/tmds_pkg.sv
// Shared TMDS constants, state encodings and the control-token detector.
package tmds_pkg;

  localparam int PHASE_W = 4;
  localparam int WORD_W  = 10;

  localparam logic [WORD_W-1:0] CTRL_TOK0 = 10'h354;
  localparam logic [WORD_W-1:0] CTRL_TOK1 = 10'h0AB;
  localparam logic [WORD_W-1:0] CTRL_TOK2 = 10'h154;
  localparam logic [WORD_W-1:0] CTRL_TOK3 = 10'h2AB;

  // Indexed by the 4-bit TERC4 data nibble
  localparam logic [15:0][WORD_W-1:0] TERC4_TOK = {
    10'h2C3, 10'h163, 10'h271, 10'h28E, 10'h2C6, 10'h19C, 10'h139, 10'h2CC,
    10'h13C, 10'h18E, 10'h11E, 10'h171, 10'h2E2, 10'h2E4, 10'h263, 10'h29C
  };

  typedef enum logic {
    AL_SEARCH,
    AL_LOCKED
  } align_state_e;

  typedef enum logic [1:0] {
    DS_WAIT,
    DS_MEASURE,
    DS_DESKEWED
  } deskew_state_e;

  function automatic logic is_ctrl_token(input logic [WORD_W-1:0] w);
    return (w == CTRL_TOK0) || (w == CTRL_TOK1) ||
           (w == CTRL_TOK2) || (w == CTRL_TOK3);
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Per-channel word boundary search: slides a 10-bit slice across two raw
// words until control tokens show up often enough to declare lock.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int TIMEOUT_BITS = 18,
  parameter int LOCK_TOKENS  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [WORD_W-1:0]  raw_in,
  output logic [WORD_W-1:0]  slice_out,
  output logic [PHASE_W-1:0] phase_out,
  output logic               locked_out
);

  localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
  localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(LOCK_TOKENS - 1);
  // Dwell expires on the increment that would land on all-ones
  localparam logic [TIMEOUT_BITS-1:0] CNT_PRE = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  align_state_e             state_q, state_d;
  logic [WORD_W-1:0]        prev_q, prev_d;
  logic [PHASE_W-1:0]       phase_q, phase_d, phase_nxt;
  logic [TIMEOUT_BITS-1:0]  cnt_q, cnt_d;
  logic [TOK_W-1:0]         tok_cnt_q, tok_cnt_d;
  logic [2*WORD_W-1:0]      window;
  logic                     hit, timeout;

  assign window     = {raw_in, prev_q};
  assign slice_out  = window[phase_q +: WORD_W];
  assign hit        = is_ctrl_token(slice_out);
  assign timeout    = (cnt_q == CNT_PRE);
  assign phase_nxt  = (phase_q == PHASE_W'(9)) ? '0 : phase_q + 1'b1;
  assign phase_out  = phase_q;
  assign locked_out = (state_q == AL_LOCKED);

  always_comb begin
    prev_d    = raw_in;
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q + 1'b1;
    tok_cnt_d = tok_cnt_q;
    if (!enable) begin
      state_d   = AL_SEARCH;
      cnt_d     = '0;
      tok_cnt_d = '0;
    end else begin
      case (state_q)
        AL_SEARCH: begin
          if (hit) begin
            if (tok_cnt_q == TOK_LAST) begin
              state_d   = AL_LOCKED;
              cnt_d     = '0;
              tok_cnt_d = '0;
            end else begin
              tok_cnt_d = tok_cnt_q + 1'b1;
              // a token on the expiring cycle restarts the dwell instead
              if (timeout) cnt_d = '0;
            end
          end else if (timeout) begin
            phase_d   = phase_nxt;
            cnt_d     = '0;
            tok_cnt_d = '0;
          end
        end
        AL_LOCKED: begin
          if (hit) begin
            cnt_d = '0;
          end else if (timeout) begin
            state_d = AL_SEARCH;
            phase_d = phase_nxt;
            cnt_d   = '0;
          end
        end
        default: state_d = AL_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= AL_SEARCH;
      prev_q    <= '0;
      phase_q   <= '0;
      cnt_q     <= '0;
      tok_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      tok_cnt_q <= tok_cnt_d;
    end
  end

endmodule

// File: rtl/tmds_channel_aligner.sv
// Word-aligns each TMDS channel, then deskews channels against each other
// by timing the blanking->active edge and delaying the early ones.
module tmds_channel_aligner
  import tmds_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int TIMEOUT_BITS = 18,
  parameter int LOCK_TOKENS  = 16,
  parameter int SKEW_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [NUM_CH*WORD_W-1:0]    raw_in,
  output logic [NUM_CH*WORD_W-1:0]    aligned_out,
  output logic [NUM_CH*PHASE_W-1:0]   ch_phase,
  output logic [NUM_CH-1:0]           ch_locked,
  output logic                        deskew_locked,
  output logic                        out_valid
);

  localparam int TAP_W = (SKEW_DEPTH > 1) ? $clog2(SKEW_DEPTH) : 1;
  localparam logic [TAP_W-1:0] MEAS_LAST = TAP_W'(SKEW_DEPTH - 1);

  logic [NUM_CH-1:0][WORD_W-1:0]                 slice, tapped;
  logic [NUM_CH-1:0][SKEW_DEPTH-1:0][WORD_W-1:0] dly_q, dly_d;
  logic [NUM_CH-1:0][WORD_W-1:0]                 aligned_q, aligned_d;
  logic [NUM_CH-1:0]                             tok0, tokt, edge0, tedge;
  logic [NUM_CH-1:0]                             tok0_prev_q, tokt_prev_q;
  logic [NUM_CH-1:0]                             arr_q, arr_d, arr_now;
  logic [NUM_CH-1:0][TAP_W-1:0]                  tap_q, tap_d, off_q, off_d, off_now;
  logic [TAP_W-1:0]                              meas_q, meas_d, max_off;
  deskew_state_e                                 ds_state_q, ds_state_d;
  logic                                          all_locked;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    tmds_word_aligner #(
      .TIMEOUT_BITS (TIMEOUT_BITS),
      .LOCK_TOKENS  (LOCK_TOKENS)
    ) u_align (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .raw_in     (raw_in[ch*WORD_W +: WORD_W]),
      .slice_out  (slice[ch]),
      .phase_out  (ch_phase[ch*PHASE_W +: PHASE_W]),
      .locked_out (ch_locked[ch])
    );
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      dly_d[ch][0] = slice[ch];
      for (int k = 1; k < SKEW_DEPTH; k++) dly_d[ch][k] = dly_q[ch][k-1];
      tapped[ch] = dly_q[ch][tap_q[ch]];
      tok0[ch]   = is_ctrl_token(dly_q[ch][0]);
      tokt[ch]   = is_ctrl_token(tapped[ch]);
    end
    aligned_d = tapped;
    edge0     = tok0_prev_q & ~tok0;
    tedge     = tokt_prev_q & ~tokt;
  end

  assign all_locked = &ch_locked;

  always_comb begin
    ds_state_d = ds_state_q;
    tap_d      = tap_q;
    off_d      = off_q;
    arr_d      = arr_q;
    meas_d     = meas_q;
    off_now    = off_q;
    arr_now    = arr_q | edge0;
    max_off    = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      if (edge0[ch] && !arr_q[ch]) off_now[ch] = meas_q;
    for (int ch = 0; ch < NUM_CH; ch++)
      if (off_now[ch] > max_off) max_off = off_now[ch];
    case (ds_state_q)
      DS_WAIT: begin
        if (all_locked && |edge0) begin
          ds_state_d = DS_MEASURE;
          arr_d      = edge0;
          off_d      = '0;
          meas_d     = TAP_W'(1);
        end
      end
      DS_MEASURE: begin
        if (!all_locked) begin
          ds_state_d = DS_WAIT;
        end else if (&arr_now) begin
          for (int ch = 0; ch < NUM_CH; ch++) tap_d[ch] = max_off - off_now[ch];
          ds_state_d = DS_DESKEWED;
        end else if (meas_q >= MEAS_LAST) begin
          ds_state_d = DS_WAIT;
        end else begin
          meas_d = meas_q + 1'b1;
          arr_d  = arr_now;
          off_d  = off_now;
        end
      end
      DS_DESKEWED: begin
        if (!all_locked || (|tedge && !(&tedge))) ds_state_d = DS_WAIT;
      end
      default: ds_state_d = DS_WAIT;
    endcase
    // A lone channel has nothing to deskew against
    if (NUM_CH == 1) begin
      ds_state_d = ch_locked[0] ? DS_DESKEWED : DS_WAIT;
      tap_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_q       <= '0;
      aligned_q   <= '0;
      tok0_prev_q <= '0;
      tokt_prev_q <= '0;
      arr_q       <= '0;
      tap_q       <= '0;
      off_q       <= '0;
      meas_q      <= '0;
      ds_state_q  <= DS_WAIT;
    end else begin
      dly_q       <= dly_d;
      aligned_q   <= aligned_d;
      tok0_prev_q <= tok0;
      tokt_prev_q <= tokt;
      arr_q       <= arr_d;
      tap_q       <= tap_d;
      off_q       <= off_d;
      meas_q      <= meas_d;
      ds_state_q  <= ds_state_d;
    end
  end

  assign aligned_out   = aligned_q;
  assign deskew_locked = (NUM_CH == 1) ? ch_locked[0] : (ds_state_q == DS_DESKEWED);
  assign out_valid     = deskew_locked;

endmodule

// File: tb/tb_tmds_channel_aligner.sv
// Directed bench for tmds_channel_aligner: phase search, lock loss, enable,
// async reset and three-channel deskew with small timeout settings.
module tb_tmds_channel_aligner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [29:0] raw_in;
  logic [29:0] aligned_out;
  logic [11:0] ch_phase;
  logic [2:0]  ch_locked;
  logic        deskew_locked;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  tmds_channel_aligner #(
    .NUM_CH       (3),
    .TIMEOUT_BITS (4),
    .LOCK_TOKENS  (4),
    .SKEW_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .raw_in        (raw_in),
    .aligned_out   (aligned_out),
    .ch_phase      (ch_phase),
    .ch_locked     (ch_locked),
    .deskew_locked (deskew_locked),
    .out_valid     (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  // 16-cycle frame: 8 token cycles then 8 data cycles, delayed by s
  function automatic logic [9:0] frame_word(input int c, input int s, input logic [9:0] tok);
    int p;
    p = (c + 64 - s) % 16;
    return (p < 8) ? tok : 10'h1F0;
  endfunction

  task automatic drive_frames(input int c, input int s0, input int s1, input int s2);
    raw_in = {frame_word(c, s2, 10'h154), frame_word(c, s1, 10'h0AB), frame_word(c, s0, 10'h354)};
  endtask

  initial begin
    logic [9:0] t2ab, offraw;
    logic       found, seen;
    int         c;
    int         eg[3];
    logic [2:0] pt;

    t2ab   = 10'h2AB;
    offraw = {t2ab[6:0], t2ab[9:7]};

    // reset state, then channel 0 finds a 3-bit offset
    reset_n = 1'b0; enable = 1'b0; raw_in = '0;
    step(); step();
    #2;
    chk("rst_aligned", aligned_out, 0);
    chk("rst_locked", ch_locked, 0);
    chk("rst_dsk_valid", {deskew_locked, out_valid}, 0);
    chk("rst_phase", ch_phase, 0);
    raw_in = {20'h0, offraw}; enable = 1'b1; reset_n = 1'b1;
    for (int e = 1; e <= 49; e++) begin
      step();
      case (e)
        14: chk("ph_e14", ch_phase[3:0], 0);
        15: chk("ph_e15", ch_phase[3:0], 1);
        29: chk("ph_e29", ch_phase[3:0], 1);
        30: chk("ph_e30", ch_phase[3:0], 2);
        45: chk("ph_e45", ch_phase[3:0], 3);
        48: chk("lock_e48", ch_locked[0], 0);
        49: chk("lock_e49", ch_locked[0], 1);
        default: ;
      endcase
    end
    repeat (5) step();
    chk("lock_hold", ch_locked[0], 1);

    // 14 non-token slices then a token on the expiring cycle: no drop
    raw_in[9:0] = '0;
    repeat (13) step();
    raw_in[9:0] = offraw;
    step();
    chk("no_drop_14", ch_locked[0], 1);
    repeat (3) step();
    chk("relock_hold", ch_locked[0], 1);
    chk("phase_kept", ch_phase[3:0], 3);

    // 15 non-token slices: drop and advance
    raw_in[9:0] = '0;
    repeat (14) step();
    chk("drop_not_yet", ch_locked[0], 1);
    step();
    chk("drop_15", ch_locked[0], 0);
    chk("drop_phase", ch_phase[3:0], 4);

    // enable low holds phase, then async reset mid-stream
    reset_n = 1'b0;
    step();
    raw_in = {20'h0, offraw}; reset_n = 1'b1;
    repeat (49) step();
    chk("c_locked", ch_locked[0], 1);
    chk("c_phase", ch_phase[3:0], 3);
    enable = 1'b0;
    step();
    chk("en_locked", ch_locked, 0);
    chk("en_phase", ch_phase[3:0], 3);
    repeat (3) step();
    chk("en_phase_hold", ch_phase[3:0], 3);
    enable = 1'b1;
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_phase", ch_phase, 0);
    chk("mid_rst_aligned", aligned_out, 0);
    chk("mid_rst_flags", {ch_locked, deskew_locked, out_valid}, 0);
    step();
    reset_n = 1'b1;
    for (int e = 1; e <= 49; e++) begin
      step();
      if (e == 14) chk("re_ph_e14", ch_phase[3:0], 0);
      if (e == 15) chk("re_ph_e15", ch_phase[3:0], 1);
      if (e == 49) chk("re_lock_e49", {ch_locked[0], ch_phase[3:0]}, {1'b1, 4'd3});
    end

    // three channels skewed 0/1/2
    reset_n = 1'b0;
    step();
    c = 0; drive_frames(c, 0, 1, 2); reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(); c++; drive_frames(c, 0, 1, 2);
      if (deskew_locked) found = 1'b1;
    end
    chk("b_dsk_locked", found, 1);
    chk("b_ch_locked", ch_locked, 3'b111);
    chk("b_taps", {dut.tap_q[2], dut.tap_q[1], dut.tap_q[0]}, {2'd0, 2'd1, 2'd2});
    chk("b_valid", out_valid, 1);
    for (int ch = 0; ch < 3; ch++) begin
      eg[ch] = -1;
      pt[ch] = is_tok(aligned_out[ch*10 +: 10]);
    end
    for (int i = 0; i < 40; i++) begin
      step(); c++; drive_frames(c, 0, 1, 2);
      for (int ch = 0; ch < 3; ch++) begin
        if (pt[ch] && !is_tok(aligned_out[ch*10 +: 10]) && eg[ch] < 0) eg[ch] = i;
        pt[ch] = is_tok(aligned_out[ch*10 +: 10]);
      end
    end
    chk("b_edge_seen", eg[0] >= 0, 1);
    chk("b_edge_ch1", eg[1], eg[0]);
    chk("b_edge_ch2", eg[2], eg[0]);
    chk("b_valid_kept", out_valid, 1);
    enable = 1'b0;
    step(); c++; drive_frames(c, 0, 1, 2);
    chk("b_en_locked", ch_locked, 0);
    step(); c++; drive_frames(c, 0, 1, 2);
    chk("b_en_dsk", {deskew_locked, out_valid}, 0);
    enable = 1'b1;

    // skew of 4 cycles cannot be corrected
    reset_n = 1'b0;
    step();
    c = 0; drive_frames(c, 0, 1, 4); reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(); c++; drive_frames(c, 0, 1, 4);
      if (deskew_locked) seen = 1'b1;
    end
    chk("d_no_dsk", seen, 0);
    chk("d_ch_locked", ch_locked, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
